game_controller: RTL and testbench

Match-level sequencer for the Pong datapath. Owns the game state (idle, serve countdown, rally, point hold, pause, game over), the two 3-bit scores and the winner colour. Gates paddle and ball motion through `run`, requests ball re-centring via `ball_reset`, and consumes one-cycle miss events from the ball-collision logic. Sits between the board keys and the image generator; all outputs are registered.

---
 rtl/game_controller.sv | 157 +++++++++++++++
 tb/tb_game_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// Pong match sequencer: game state, scores, winner colour and ball/paddle gating.
// Every output is registered; `state` is the encoded FSM register itself.
module game_controller #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       key_continue,
  input  logic       key_pause,
  input  logic       point_1,
  input  logic       point_2,
  output logic       run,
  output logic       ball_reset,
  output logic       serve_left,
  output logic [2:0] score_1,
  output logic [2:0] score_2,
  output logic [2:0] winner_color,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SERVE    = 3'd1,
    S_PLAY     = 3'd2,
    S_POINT    = 3'd3,
    S_PAUSED   = 3'd4,
    S_GAMEOVER = 3'd5
  } state_t;

  localparam logic [7:0] SERVE_CNT = 8'(SERVE_FRAMES);
  localparam logic [7:0] POINT_CNT = 8'(POINT_FRAMES);
  localparam logic [2:0] WIN       = 3'(WIN_SCORE);

  state_t     state_q;
  state_t     resume_q;
  logic [7:0] counter;
  logic       cont_prev;
  logic       pause_prev;
  logic       cont_press;
  logic       pause_press;
  logic [2:0] score_1_inc;
  logic [2:0] score_2_inc;

  // A simultaneous pause press always suppresses the continue press.
  assign pause_press = pause_prev & ~key_pause;
  assign cont_press  = cont_prev & ~key_continue & ~pause_press;
  assign score_1_inc = score_1 + 3'd1;
  assign score_2_inc = score_2 + 3'd1;
  assign state       = state_q;

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state_q      <= S_IDLE;
      resume_q     <= S_IDLE;
      counter      <= '0;
      cont_prev    <= 1'b1;
      pause_prev   <= 1'b1;
      run          <= 1'b0;
      ball_reset   <= 1'b0;
      serve_left   <= 1'b0;
      score_1      <= '0;
      score_2      <= '0;
      winner_color <= '0;
    end else begin
      cont_prev  <= key_continue;
      pause_prev <= key_pause;
      ball_reset <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cont_press) begin
            state_q    <= S_SERVE;
            ball_reset <= 1'b1;
            counter    <= SERVE_CNT;
          end
        end
        S_SERVE: begin
          if (pause_press) begin
            state_q  <= S_PAUSED;
            resume_q <= S_SERVE;
          end else if (frame_tick) begin
            if (counter == 8'd1) begin
              state_q <= S_PLAY;
              run     <= 1'b1;
            end else begin
              counter <= counter - 8'd1;
            end
          end
        end
        S_PLAY: begin
          // Point events outrank a pause press; point_1 outranks point_2.
          if (point_1) begin
            run        <= 1'b0;
            score_1    <= score_1_inc;
            serve_left <= 1'b0;
            if (score_1_inc == WIN) begin
              state_q      <= S_GAMEOVER;
              winner_color <= 3'b001;
            end else begin
              state_q <= S_POINT;
              counter <= POINT_CNT;
            end
          end else if (point_2) begin
            run        <= 1'b0;
            score_2    <= score_2_inc;
            serve_left <= 1'b1;
            if (score_2_inc == WIN) begin
              state_q      <= S_GAMEOVER;
              winner_color <= 3'b100;
            end else begin
              state_q <= S_POINT;
              counter <= POINT_CNT;
            end
          end else if (pause_press) begin
            run      <= 1'b0;
            state_q  <= S_PAUSED;
            resume_q <= S_PLAY;
          end
        end
        S_POINT: begin
          if (frame_tick) begin
            if (counter == 8'd1) begin
              state_q    <= S_SERVE;
              ball_reset <= 1'b1;
              counter    <= SERVE_CNT;
            end else begin
              counter <= counter - 8'd1;
            end
          end
        end
        S_PAUSED: begin
          if (cont_press) begin
            state_q <= resume_q;
            run     <= (resume_q == S_PLAY);
          end
        end
        S_GAMEOVER: begin
          if (cont_press) begin
            state_q      <= S_SERVE;
            ball_reset   <= 1'b1;
            counter      <= SERVE_CNT;
            score_1      <= '0;
            score_2      <= '0;
            winner_color <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          run     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: stimulus queues expected output snapshots,
// a negedge monitor pops and compares them against the DUT.
module tb_game_controller;

  logic       CLOCK_25 = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       key_continue = 1'b1;
  logic       key_pause = 1'b1;
  logic       point_1 = 1'b0;
  logic       point_2 = 1'b0;
  logic       run;
  logic       ball_reset;
  logic       serve_left;
  logic [2:0] score_1;
  logic [2:0] score_2;
  logic [2:0] winner_color;
  logic [2:0] state;

  game_controller #(
    .WIN_SCORE   (2),
    .SERVE_FRAMES(60),
    .POINT_FRAMES(90)
  ) dut (
    .CLOCK_25    (CLOCK_25),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .key_continue(key_continue),
    .key_pause   (key_pause),
    .point_1     (point_1),
    .point_2     (point_2),
    .run         (run),
    .ball_reset  (ball_reset),
    .serve_left  (serve_left),
    .score_1     (score_1),
    .score_2     (score_2),
    .winner_color(winner_color),
    .state       (state)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  typedef struct {
    string       name;
    logic [14:0] v;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur;
  logic [14:0] got;
  int          n_checks = 0;
  int          n_pass = 0;

  // Fields: state, run, ball_reset, serve_left, score_1, score_2, winner_color
  always @(negedge CLOCK_25) begin
    while (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      got = {state, run, ball_reset, serve_left, score_1, score_2, winner_color};
      n_checks++;
      if (got !== cur.v)
        $display("FAIL %s got st=%0d run=%b br=%b sl=%b s1=%0d s2=%0d wc=%b exp st=%0d run=%b br=%b sl=%b s1=%0d s2=%0d wc=%b",
                 cur.name, got[14:12], got[11], got[10], got[9], got[8:6], got[5:3], got[2:0],
                 cur.v[14:12], cur.v[11], cur.v[10], cur.v[9], cur.v[8:6], cur.v[5:3], cur.v[2:0]);
      else
        n_pass++;
    end
  end

  function automatic void chk(string name, logic [2:0] st, logic r, logic br, logic sl,
                              logic [2:0] s1, logic [2:0] s2, logic [2:0] wc);
    exp_t e;
    e.name = name;
    e.v    = {st, r, br, sl, s1, s2, wc};
    sb_q.push_back(e);
  endfunction

  task automatic step();
    @(posedge CLOCK_25);
    #1;
  endtask

  task automatic tick_once();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_once();
      step();
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    reset = 1'b0;
    chk("reset", 3'd0, 0, 0, 0, 3'd0, 3'd0, 3'b000);

    key_continue = 1'b0;
    step();
    chk("serve_entry", 3'd1, 0, 1, 0, 3'd0, 3'd0, 3'b000);
    step();
    chk("held_key_one_press", 3'd1, 0, 0, 0, 3'd0, 3'd0, 3'b000);
    key_continue = 1'b1;
    step();
    ticks(59);
    chk("serve_tick59", 3'd1, 0, 0, 0, 3'd0, 3'd0, 3'b000);
    ticks(1);
    chk("play_after60", 3'd2, 1, 0, 0, 3'd0, 3'd0, 3'b000);

    point_2 = 1'b1;
    step();
    point_2 = 1'b0;
    chk("point2", 3'd3, 0, 0, 1, 3'd0, 3'd1, 3'b000);
    key_pause = 1'b0;
    step();
    key_pause = 1'b1;
    chk("pause_ignored_point", 3'd3, 0, 0, 1, 3'd0, 3'd1, 3'b000);
    step();
    ticks(89);
    chk("point_tick89", 3'd3, 0, 0, 1, 3'd0, 3'd1, 3'b000);
    tick_once();
    chk("point_to_serve", 3'd1, 0, 1, 1, 3'd0, 3'd1, 3'b000);
    step();
    chk("ball_reset_one_cycle", 3'd1, 0, 0, 1, 3'd0, 3'd1, 3'b000);

    ticks(30);
    key_pause = 1'b0;
    step();
    chk("pause_in_serve", 3'd4, 0, 0, 1, 3'd0, 3'd1, 3'b000);
    key_pause = 1'b1;
    step();
    ticks(100);
    chk("paused_frozen", 3'd4, 0, 0, 1, 3'd0, 3'd1, 3'b000);
    key_continue = 1'b0;
    step();
    chk("resume_serve", 3'd1, 0, 0, 1, 3'd0, 3'd1, 3'b000);
    key_continue = 1'b1;
    step();
    ticks(29);
    chk("resume_tick29", 3'd1, 0, 0, 1, 3'd0, 3'd1, 3'b000);
    ticks(1);
    chk("resume_play_30", 3'd2, 1, 0, 1, 3'd0, 3'd1, 3'b000);

    point_1 = 1'b1;
    point_2 = 1'b1;
    step();
    point_1 = 1'b0;
    point_2 = 1'b0;
    chk("both_points", 3'd3, 0, 0, 0, 3'd1, 3'd1, 3'b000);
    point_2 = 1'b1;
    step();
    point_2 = 1'b0;
    chk("point_ignored_in_point", 3'd3, 0, 0, 0, 3'd1, 3'd1, 3'b000);
    ticks(90);
    ticks(60);
    chk("play_again", 3'd2, 1, 0, 0, 3'd1, 3'd1, 3'b000);

    point_1 = 1'b1;
    step();
    point_1 = 1'b0;
    chk("gameover_p1", 3'd5, 0, 0, 0, 3'd2, 3'd1, 3'b001);
    ticks(5);
    chk("gameover_holds", 3'd5, 0, 0, 0, 3'd2, 3'd1, 3'b001);
    key_continue = 1'b0;
    step();
    key_continue = 1'b1;
    chk("new_match", 3'd1, 0, 1, 0, 3'd0, 3'd0, 3'b000);
    step();
    ticks(60);
    chk("play_new_match", 3'd2, 1, 0, 0, 3'd0, 3'd0, 3'b000);

    key_continue = 1'b0;
    key_pause    = 1'b0;
    step();
    chk("pause_beats_continue", 3'd4, 0, 0, 0, 3'd0, 3'd0, 3'b000);
    key_pause = 1'b1;
    step();
    step();
    chk("held_continue_no_resume", 3'd4, 0, 0, 0, 3'd0, 3'd0, 3'b000);
    point_1 = 1'b1;
    step();
    point_1 = 1'b0;
    point_2 = 1'b1;
    step();
    point_2 = 1'b0;
    chk("points_ignored_paused", 3'd4, 0, 0, 0, 3'd0, 3'd0, 3'b000);
    key_continue = 1'b1;
    step();
    key_continue = 1'b0;
    step();
    key_continue = 1'b1;
    chk("resume_play", 3'd2, 1, 0, 0, 3'd0, 3'd0, 3'b000);

    point_1 = 1'b1;
    key_pause = 1'b0;
    step();
    point_1 = 1'b0;
    key_pause = 1'b1;
    chk("point_beats_pause", 3'd3, 0, 0, 0, 3'd1, 3'd0, 3'b000);
    ticks(10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_in_point", 3'd0, 0, 0, 0, 3'd0, 3'd0, 3'b000);

    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge CLOCK_25);
    @(posedge CLOCK_25);
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
